// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates two register-file write requesters (A: ALU writeback,
// B: load writeback) onto a single register-file write port.
//
// Arbitration
//   - A lone valid requester is always granted.
//   - When both are valid, the requester that did NOT win most recently is
//     granted (two-way round robin), so contention alternates A,B,A,B...
//   - Ready is combinational from the valids and last_grant, and is held
//     low while rst_n is low.
//
// Output stage
//   - A single register stage sits between acceptance and the register file.
//     An accepted legal write produces write_enable one cycle later, together
//     with its address and data.
//   - An accepted write to an unimplemented register (addr >= NUM_REGS) is
//     consumed but dropped: bad_addr pulses instead of write_enable, and a
//     saturating 8-bit drop counter is incremented.
//   - write_address/data_in hold their previous values whenever no legal write
//     is being presented.
//
// Ports
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   a_valid/addr/data in  requester A write request
//   a_ready        out  requester A accepted this cycle
//   b_valid/addr/data in  requester B write request
//   b_ready        out  requester B accepted this cycle
//   write_enable   out  register file write strobe
//   write_address  out  register file write address
//   data_in        out  register file write data
//   bad_addr       out  one-cycle pulse for an accepted illegal address
//   last_grant     out  0 = A granted most recently, 1 = B
//   drop_count     out  saturating count of dropped illegal writes
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NUM_REGS = 24,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] data_in,
    output logic              bad_addr,
    output logic              last_grant,
    output logic [7:0]        drop_count
);

    localparam int unsigned NUM_REGS_U = NUM_REGS;
    localparam logic [7:0]  DROP_MAX   = 8'hFF;

    // Registered state
    logic              write_enable_r;
    logic [ADDR_W-1:0] write_address_r;
    logic [DATA_W-1:0] data_in_r;
    logic              bad_addr_r;
    logic              last_grant_r;
    logic [7:0]        drop_count_r;

    // Combinational arbitration / next-state
    logic              grant_a_s;
    logic              grant_b_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [31:0]       sel_addr_ext_s;
    logic              addr_legal_s;

    logic              write_enable_nxt_s;
    logic [ADDR_W-1:0] write_address_nxt_s;
    logic [DATA_W-1:0] data_in_nxt_s;
    logic              bad_addr_nxt_s;
    logic              last_grant_nxt_s;
    logic [7:0]        drop_count_nxt_s;

    // Round-robin grant: lone requester wins, contention goes to the one not named by last_grant
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (!rst_n) begin
            // Readies are forced low for the whole reset window.
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else begin
            case ({a_valid, b_valid})
                2'b10: grant_a_s = 1'b1;
                2'b01: grant_b_s = 1'b1;
                2'b11: begin
                    if (last_grant_r) begin
                        grant_a_s = 1'b1;
                    end else begin
                        grant_b_s = 1'b1;
                    end
                end
                default: begin
                    grant_a_s = 1'b0;
                    grant_b_s = 1'b0;
                end
            endcase
        end
    end

    assign a_ready = grant_a_s;
    assign b_ready = grant_b_s;
    assign xfer_s  = grant_a_s | grant_b_s;

    // Select the granted request and classify its address
    always_comb begin
        sel_addr_s     = a_addr;
        sel_data_s     = a_data;
        if (grant_b_s) begin
            sel_addr_s = b_addr;
            sel_data_s = b_data;
        end else begin
            sel_addr_s = a_addr;
            sel_data_s = a_data;
        end
        // Compare in 32 bits so NUM_REGS == 2**ADDR_W cannot overflow.
        sel_addr_ext_s = 32'(sel_addr_s);
        addr_legal_s   = (sel_addr_ext_s < NUM_REGS_U);
    end

    // Next-state for the output stage, grant history and drop counter
    always_comb begin
        write_enable_nxt_s  = 1'b0;
        bad_addr_nxt_s      = 1'b0;
        write_address_nxt_s = write_address_r;
        data_in_nxt_s       = data_in_r;
        last_grant_nxt_s    = last_grant_r;
        drop_count_nxt_s    = drop_count_r;

        if (xfer_s) begin
            last_grant_nxt_s = grant_b_s;
            if (addr_legal_s) begin
                write_enable_nxt_s  = 1'b1;
                write_address_nxt_s = sel_addr_s;
                data_in_nxt_s       = sel_data_s;
            end else begin
                bad_addr_nxt_s = 1'b1;
                if (drop_count_r != DROP_MAX) begin
                    drop_count_nxt_s = drop_count_r + 8'd1;
                end else begin
                    drop_count_nxt_s = drop_count_r;
                end
            end
        end else begin
            last_grant_nxt_s = last_grant_r;
        end
    end

    // State registers; last_grant resets to B so A wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_enable_r  <= 1'b0;
            write_address_r <= '0;
            data_in_r       <= '0;
            bad_addr_r      <= 1'b0;
            last_grant_r    <= 1'b1;
            drop_count_r    <= 8'd0;
        end else begin
            write_enable_r  <= write_enable_nxt_s;
            write_address_r <= write_address_nxt_s;
            data_in_r       <= data_in_nxt_s;
            bad_addr_r      <= bad_addr_nxt_s;
            last_grant_r    <= last_grant_nxt_s;
            drop_count_r    <= drop_count_nxt_s;
        end
    end

    assign write_enable  = write_enable_r;
    assign write_address = write_address_r;
    assign data_in       = data_in_r;
    assign bad_addr      = bad_addr_r;
    assign last_grant    = last_grant_r;
    assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed self-checking bench for regfile_write_arbiter. Inputs are driven
// on the falling edge; readies are sampled 1 time unit later, registered
// outputs 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int NUM_REGS = 24;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              clk;
    logic              rst_n;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] data_in;
    logic              bad_addr;
    logic              last_grant;
    logic [7:0]        drop_count;

    int n_checks;
    int n_fail;

    regfile_write_arbiter #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .write_enable (write_enable),
        .write_address(write_address),
        .data_in      (data_in),
        .bad_addr     (bad_addr),
        .last_grant   (last_grant),
        .drop_count   (drop_count)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive both requesters at the falling edge
    task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        a_valid  = 1'b0; a_addr = '0; a_data = '0;
        b_valid  = 1'b0; b_addr = '0; b_data = '0;

        // ---------------- reset state ----------------
        #2 rst_n = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        check_val("rst_we",    32'(write_enable),  32'd0);
        check_val("rst_bad",   32'(bad_addr),      32'd0);
        check_val("rst_waddr", 32'(write_address), 32'd0);
        check_val("rst_data",  32'(data_in),       32'd0);
        check_val("rst_drop",  32'(drop_count),    32'd0);
        check_val("rst_lg",    32'(last_grant),    32'd1);
        check_val("rst_ardy",  32'(a_ready),       32'd0);
        check_val("rst_brdy",  32'(b_ready),       32'd0);
        post_edge();
        check_val("rst_we_edge", 32'(write_enable), 32'd0);

        // release with nothing pending
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;

        // ---------------- single A write ----------------
        drive(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'h0);
        check_val("single_ardy", 32'(a_ready), 32'd1);
        check_val("single_brdy", 32'(b_ready), 32'd0);
        post_edge();
        check_val("single_we",    32'(write_enable),  32'd1);
        check_val("single_waddr", 32'(write_address), 32'd3);
        check_val("single_data",  32'(data_in),       32'h55);
        check_val("single_lg",    32'(last_grant),    32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_val("idle_ardy", 32'(a_ready), 32'd0);
        post_edge();
        check_val("idle_we",    32'(write_enable),  32'd0);
        check_val("idle_bad",   32'(bad_addr),      32'd0);
        check_val("hold_waddr", 32'(write_address), 32'd3);
        check_val("hold_data",  32'(data_in),       32'h55);
        check_val("hold_lg",    32'(last_grant),    32'd0);

        // lone B write
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234_5678);
        check_val("lone_b_brdy", 32'(b_ready), 32'd1);
        check_val("lone_b_ardy", 32'(a_ready), 32'd0);
        post_edge();
        check_val("lone_b_waddr", 32'(write_address), 32'd9);
        check_val("lone_b_data",  32'(data_in),       32'h1234_5678);
        check_val("lone_b_lg",    32'(last_grant),    32'd1);

        // ---------------- contention after reset ----------------
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 32'hA0 + 32'(i), 1'b1, 5'd2, 32'hB0 + 32'(i));
            check_val($sformatf("cont%0d_ardy", i), 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("cont%0d_brdy", i), 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            post_edge();
            check_val($sformatf("cont%0d_we", i),    32'(write_enable), 32'd1);
            check_val($sformatf("cont%0d_waddr", i), 32'(write_address),
                      (i % 2 == 0) ? 32'd1 : 32'd2);
            check_val($sformatf("cont%0d_data", i),  32'(data_in),
                      (i % 2 == 0) ? (32'hA0 + 32'(i)) : (32'hB0 + 32'(i)));
        end
        check_val("cont_lg_end", 32'(last_grant), 32'd1);

        // ---------------- illegal addresses ----------------
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 32'hBAD0);
        check_val("ill24_brdy", 32'(b_ready), 32'd1);
        post_edge();
        check_val("ill24_we",    32'(write_enable),  32'd0);
        check_val("ill24_bad",   32'(bad_addr),      32'd1);
        check_val("ill24_drop",  32'(drop_count),    32'd1);
        check_val("ill24_waddr", 32'(write_address), 32'd2);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hBAD1);
        check_val("ill31_brdy", 32'(b_ready), 32'd1);
        post_edge();
        check_val("ill31_we",   32'(write_enable), 32'd0);
        check_val("ill31_bad",  32'(bad_addr),     32'd1);
        check_val("ill31_drop", 32'(drop_count),   32'd2);
        check_val("ill31_data", 32'(data_in),      32'hB3);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        post_edge();
        check_val("ill_idle_bad",  32'(bad_addr),   32'd0);
        check_val("ill_idle_drop", 32'(drop_count), 32'd2);

        // ---------------- saturation: 258 more illegal writes (260 total) ----------------
        for (int i = 0; i < 258; i++) begin
            drive(1'b1, 5'd30, 32'(i), 1'b0, 5'd0, 32'h0);
            post_edge();
        end
        check_val("sat_drop_260", 32'(drop_count), 32'd255);
        check_val("sat_bad",      32'(bad_addr),   32'd1);
        drive(1'b1, 5'd25, 32'h0, 1'b0, 5'd0, 32'h0);
        post_edge();
        check_val("sat_drop_hold", 32'(drop_count), 32'd255);
        // highest legal address still writes normally
        drive(1'b1, 5'd23, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        check_val("sat_legal_ardy", 32'(a_ready), 32'd1);
        post_edge();
        check_val("sat_legal_we",    32'(write_enable),  32'd1);
        check_val("sat_legal_bad",   32'(bad_addr),      32'd0);
        check_val("sat_legal_waddr", 32'(write_address), 32'd23);
        check_val("sat_legal_data",  32'(data_in),       32'hDEAD_BEEF);
        check_val("sat_legal_drop",  32'(drop_count),    32'd255);

        // ---------------- reset mid-traffic ----------------
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h66);
        post_edge();
        post_edge();
        check_val("mid_we_before", 32'(write_enable), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_we",    32'(write_enable),  32'd0);
        check_val("mid_rst_waddr", 32'(write_address), 32'd0);
        check_val("mid_rst_data",  32'(data_in),       32'd0);
        check_val("mid_rst_drop",  32'(drop_count),    32'd0);
        check_val("mid_rst_lg",    32'(last_grant),    32'd1);
        check_val("mid_rst_ardy",  32'(a_ready),       32'd0);
        check_val("mid_rst_brdy",  32'(b_ready),       32'd0);
        post_edge();
        check_val("mid_rst_we_edge", 32'(write_enable), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("mid_rel_ardy", 32'(a_ready), 32'd1);
        check_val("mid_rel_brdy", 32'(b_ready), 32'd0);
        post_edge();
        check_val("mid_rel_we",    32'(write_enable),  32'd1);
        check_val("mid_rel_waddr", 32'(write_address), 32'd4);
        check_val("mid_rel_lg",    32'(last_grant),    32'd0);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        post_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
